// File: rtl/ps2_cmd_tx_if.sv
// Request/status bundle between a message requester and the ps2_cmd_tx serializer.
interface ps2_cmd_tx_if;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] temp_dec;
    logic [7:0] temp_uni;
    logic       peligro;
    logic       gas;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic       done;

    // start is a one-cycle request taken only while busy=0 (no queueing); done pulses in the first idle cycle.
    modport master (output start, cmd, temp_dec, temp_uni, peligro, gas,
                    input  ps2_clk, ps2_data, busy, done);
    modport slave  (input  start, cmd, temp_dec, temp_uni, peligro, gas,
                    output ps2_clk, ps2_data, busy, done);
endinterface

// File: rtl/ps2_cmd_tx.sv
// Device-side PS/2 serializer for the I-prefixed keyboard command messages.
// Optional break codes after every non-leading byte: define PS2_BREAK_CODE_EN.
module ps2_cmd_tx #(
    parameter int CLK_DIV = 2500,
    parameter int GAP_CYC = 5000
) (
    input  logic         i_clk,
    input  logic         i_rst,
    ps2_cmd_tx_if.slave  bus,
    output logic [1:0]   o_dbg_state
);
    localparam int DIV_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
`ifdef PS2_BREAK_CODE_EN
    localparam int BYTE_W  = 4;
`else
    localparam int BYTE_W  = 2;
`endif
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(GAP_CYC - 1);

    // Byte load happens on the edge that enters BIT_HI, so loading costs no cycle of its own.
    typedef enum logic [1:0] {ST_IDLE, ST_BIT_HI, ST_BIT_LO, ST_GAP} state_t;

    state_t            r_state, w_state;
    logic [DIV_W-1:0]  r_div, w_div;
    logic [3:0]        r_bit_idx, w_bit_idx;
    logic [BYTE_W-1:0] r_byte_idx, w_byte_idx;
    logic              r_data, w_data;
    logic              r_done, w_done;
    logic              w_latch;
    logic [1:0]        r_cmd;
    logic [7:0]        r_dec, r_uni;
    logic              r_pel, r_gas;
    logic [7:0]        w_cur_byte;
    logic [BYTE_W-1:0] w_last_idx;

    function automatic logic [7:0] make_byte(input logic [1:0] j, input logic [1:0] c,
                                             input logic [7:0] dec, input logic [7:0] uni,
                                             input logic pel, input logic g);
        logic [7:0] b;
        b = 8'h43;
        case (j)
            2'd1: case (c)
                      2'd0:    b = 8'h5A;
                      2'd1:    b = 8'h33;
                      2'd2:    b = 8'h34;
                      default: b = 8'h2D;
                  endcase
            2'd2: case (c)
                      2'd0:    b = dec;
                      2'd1:    b = pel ? 8'h4D : 8'h1C;
                      default: b = g ? 8'h35 : 8'h31;
                  endcase
            2'd3:    b = uni;
            default: b = 8'h43;
        endcase
        return b;
    endfunction

    // Frame slot: 0 start, 1..8 data LSB first, 9 odd parity, 10 stop.
    function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] b);
        logic v;
        v = 1'b1;
        if (idx == 4'd0)
            v = 1'b0;
        else if (idx <= 4'd8)
            v = b[3'(idx - 4'd1)];
        else if (idx == 4'd9)
            v = ~^b;
        return v;
    endfunction

`ifdef PS2_BREAK_CODE_EN
    logic [1:0] w_sel_make;
    logic       w_sel_brk;

    // Stream is make0, then for each later make byte m: m, F0, m.
    always_comb begin
        w_sel_make = 2'd0;
        w_sel_brk  = 1'b0;
        case (r_byte_idx)
            4'd1, 4'd3: w_sel_make = 2'd1;
            4'd4, 4'd6: w_sel_make = 2'd2;
            4'd7, 4'd9: w_sel_make = 2'd3;
            4'd2, 4'd5, 4'd8: w_sel_brk = 1'b1;
            default:    w_sel_make = 2'd0;
        endcase
        w_cur_byte = w_sel_brk ? 8'hF0 : make_byte(w_sel_make, r_cmd, r_dec, r_uni, r_pel, r_gas);
        case (r_cmd)
            2'd0:       w_last_idx = 4'd9;
            2'd1, 2'd2: w_last_idx = 4'd6;
            default:    w_last_idx = 4'd3;
        endcase
    end
`else
    always_comb begin
        w_cur_byte = make_byte(r_byte_idx, r_cmd, r_dec, r_uni, r_pel, r_gas);
        case (r_cmd)
            2'd0:       w_last_idx = 2'd3;
            2'd1, 2'd2: w_last_idx = 2'd2;
            default:    w_last_idx = 2'd1;
        endcase
    end
`endif

    always_comb begin
        w_state    = r_state;
        w_div      = r_div;
        w_bit_idx  = r_bit_idx;
        w_byte_idx = r_byte_idx;
        w_data     = r_data;
        w_done     = 1'b0;
        w_latch    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_latch    = 1'b1;
                    w_state    = ST_BIT_HI;
                    w_div      = '0;
                    w_bit_idx  = 4'd0;
                    w_byte_idx = '0;
                    w_data     = 1'b0;
                end
            end
            ST_BIT_HI: begin
                if (r_div == HALF_LAST) begin
                    w_state = ST_BIT_LO;
                    w_div   = '0;
                end else begin
                    w_div = r_div + 1'b1;
                end
            end
            ST_BIT_LO: begin
                if (r_div == HALF_LAST) begin
                    w_div = '0;
                    if (r_bit_idx == 4'd10) begin
                        w_state = ST_GAP;
                    end else begin
                        w_state   = ST_BIT_HI;
                        w_bit_idx = r_bit_idx + 4'd1;
                        w_data    = frame_bit(r_bit_idx + 4'd1, w_cur_byte);
                    end
                end else begin
                    w_div = r_div + 1'b1;
                end
            end
            ST_GAP: begin
                if (r_div == GAP_LAST) begin
                    w_div = '0;
                    // Byte index stops at the last byte instead of wrapping.
                    if (r_byte_idx == w_last_idx) begin
                        w_state = ST_IDLE;
                        w_done  = 1'b1;
                    end else begin
                        w_state    = ST_BIT_HI;
                        w_byte_idx = r_byte_idx + 1'b1;
                        w_bit_idx  = 4'd0;
                        w_data     = 1'b0;
                    end
                end else begin
                    w_div = r_div + 1'b1;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_div      <= '0;
            r_bit_idx  <= 4'd0;
            r_byte_idx <= '0;
            r_data     <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_div      <= w_div;
            r_bit_idx  <= w_bit_idx;
            r_byte_idx <= w_byte_idx;
            r_data     <= w_data;
            r_done     <= w_done;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cmd <= 2'd0;
            r_dec <= 8'h00;
            r_uni <= 8'h00;
            r_pel <= 1'b0;
            r_gas <= 1'b0;
        end else if (w_latch) begin
            r_cmd <= bus.cmd;
            r_dec <= bus.temp_dec;
            r_uni <= bus.temp_uni;
            r_pel <= bus.peligro;
            r_gas <= bus.gas;
        end
    end

    assign bus.ps2_clk  = (r_state != ST_BIT_LO);
    assign bus.ps2_data = r_data;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.done     = r_done;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_ps2_cmd_tx.sv
// Scoreboard bench for ps2_cmd_tx: falling-edge frame capture and busy/done timing vs a message-level model.
module tb_ps2_cmd_tx;
    localparam int CLK_DIV  = 4;
    localparam int GAP_CYC  = 8;
    localparam int BYTE_CYC = 22 * CLK_DIV + GAP_CYC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_applied = 1'b1;
    logic [1:0] dbg_state;

    ps2_cmd_tx_if bus();

    ps2_cmd_tx #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rst_applied <= rst;

    int checks = 0;
    int errors = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] len_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Message model: list of make codes, optionally expanded with break pairs.
    task automatic push_expected(input logic [1:0] c, input logic [7:0] d, input logic [7:0] u,
                                 input logic p, input logic g);
        logic [7:0] mk[$];
        int n;
        mk.push_back(8'h43);
        case (c)
            2'd0: begin mk.push_back(8'h5A); mk.push_back(d); mk.push_back(u); end
            2'd1: begin mk.push_back(8'h33); mk.push_back(p ? 8'h4D : 8'h1C); end
            2'd2: begin mk.push_back(8'h34); mk.push_back(g ? 8'h35 : 8'h31); end
            default: mk.push_back(8'h2D);
        endcase
        n = 0;
        foreach (mk[i]) begin
            exp_q.push_back(mk[i]); n++;
`ifdef PS2_BREAK_CODE_EN
            if (i > 0) begin
                exp_q.push_back(8'hF0);
                exp_q.push_back(mk[i]);
                n += 2;
            end
`endif
        end
        len_q.push_back(32'(n * BYTE_CYC));
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 20000 && bus.busy !== 1'b0; k++) @(negedge clk);
        if (bus.busy !== 1'b0) chk("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] d, input logic [7:0] u,
                        input logic p, input logic g);
        wait_idle();
        bus.cmd = c; bus.temp_dec = d; bus.temp_uni = u; bus.peligro = p; bus.gas = g;
        bus.start = 1'b1;
        push_expected(c, d, u, p, g);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.cmd      = 2'($urandom_range(0, 3));
        bus.temp_dec = 8'($urandom);
        bus.temp_uni = 8'($urandom);
        bus.peligro  = 1'($urandom);
        bus.gas      = 1'($urandom);
    endtask

    // Monitor: decodes frames on ps2_clk falling edges and times busy/done.
    logic        prev_clk = 1'b1, prev_data = 1'b1, prev_busy = 1'b0;
    logic [10:0] bits;
    int          nbits = 0, busy_cnt = 0, low_cnt = 0;

    always @(negedge clk) begin
        if (rst_applied) begin
            chk("rst_done", 32'(bus.done), 32'd0);
            nbits = 0; busy_cnt = 0; low_cnt = 0;
            prev_clk = 1'b1; prev_data = 1'b1; prev_busy = 1'b0;
        end else begin
            chk("done", 32'(bus.done), 32'(prev_busy && !bus.busy));
            if (prev_busy && !bus.busy) begin
                if (len_q.size() == 0) chk("unexpected_end", 32'd1, 32'd0);
                else chk("busy_len", 32'(busy_cnt), len_q.pop_front());
                busy_cnt = 0;
            end
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.ps2_data !== prev_data) chk("data_while_clk_low", 32'(bus.ps2_clk), 32'd1);
            if (bus.ps2_clk === 1'b0) low_cnt++;
            if (prev_clk === 1'b0 && bus.ps2_clk === 1'b1) begin
                chk("low_phase", 32'(low_cnt), 32'(CLK_DIV));
                low_cnt = 0;
            end
            if (prev_clk === 1'b1 && bus.ps2_clk === 1'b0) begin
                bits[nbits] = bus.ps2_data;
                nbits++;
                if (nbits == 11) begin
                    nbits = 0;
                    chk("start_bit", 32'(bits[0]), 32'd0);
                    chk("stop_bit", 32'(bits[10]), 32'd1);
                    chk("parity", 32'(^bits[9:1]), 32'd1);
                    if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
                    else chk("byte", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
                end
            end
            prev_clk = bus.ps2_clk; prev_data = bus.ps2_data; prev_busy = bus.busy;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        bus.start = 1'b0; bus.cmd = 2'd0; bus.temp_dec = 8'h00; bus.temp_uni = 8'h00;
        bus.peligro = 1'b0; bus.gas = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) begin
            @(negedge clk);
            chk("idle_clk", 32'(bus.ps2_clk), 32'd1);
            chk("idle_data", 32'(bus.ps2_data), 32'd1);
            chk("idle_busy", 32'(bus.busy), 32'd0);
        end

        send(2'd0, 8'h1E, 8'h2E, 1'b0, 1'b0);
        send(2'd1, 8'h00, 8'h00, 1'b1, 1'b0);
        send(2'd2, 8'h00, 8'h00, 1'b0, 1'b0);

        // Extra start in mid-message is dropped.
        send(2'd3, 8'h11, 8'h22, 1'b0, 1'b1);
        repeat (BYTE_CYC + 10) @(negedge clk);
        bus.cmd = 2'd0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        // Reset at bit 5 of byte 2, then reset with simultaneous start.
        send(2'd0, 8'h16, 8'h1E, 1'b0, 1'b0);
        repeat (2 * BYTE_CYC + 5 * 2 * CLK_DIV + 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_clk", 32'(bus.ps2_clk), 32'd1);
        chk("rst_data", 32'(bus.ps2_data), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        exp_q.delete();
        len_q.delete();
        bus.start = 1'b1; bus.cmd = 2'd3;
        @(negedge clk);
        bus.start = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("rst_start_dropped", 32'(bus.busy), 32'd0);
        send(2'd3, 8'h00, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++)
            send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom));

        wait_idle();
        repeat (5) @(negedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("len_q_empty", 32'(len_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_cmd_tx.md
Name: ps2_cmd_tx

Overview:
- Device-side PS/2 serializer: emits the command sequences the keyboard-command receiver parses (I-prefixed temperature, alarm, gas and reset messages) as PS/2 frames on a clock/data pair.
- Used by the test station and the loopback path to drive the receiver without a physical keyboard.
- A message is selected and latched on a start pulse, then sent byte by byte.

Parameters:
- CLK_DIV, 2500: CLK cycles per PS/2 clock half-period (50 MHz system clock gives a 10 kHz PS/2 clock).
- GAP_CYC, 5000: idle CLK cycles (both lines high) after every byte.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- cmd  in  2  message select, latched on accept: 0=TEMP, 1=ALARM, 2=GAS, 3=RESET.
- temp_dec  in  8  tens-digit scan code, latched on accept.
- temp_uni  in  8  units-digit scan code, latched on accept.
- peligro  in  1  ALARM variant: 1 sends P, 0 sends A.
- gas  in  1  GAS variant: 1 sends Y, 0 sends N.
- ps2_clk  out  1  PS/2 clock, idle high.
- ps2_data  out  1  PS/2 data, idle high.
- busy  out  1  high while a message is in progress.
- done  out  1  one-cycle pulse when a message ends.

Behaviour:
- Reset values: ps2_clk=1, ps2_data=1, busy=0, done=0; all counters 0; FSM in IDLE.
- Scan codes:
  - I=0x43, Enter=0x5A, Reset=0x2D, H=0x33, A=0x1C, P=0x4D, G=0x34, Y=0x35, N=0x31.
- Byte sequences:
  - TEMP: 0x43, 0x5A, temp_dec, temp_uni (4 bytes).
  - ALARM: 0x43, 0x33, 0x4D if peligro else 0x1C (3 bytes).
  - GAS: 0x43, 0x34, 0x35 if gas else 0x31 (3 bytes).
  - RESET: 0x43, 0x2D (2 bytes).
- Accept: start=1 and busy=0 at edge k latches cmd, temp_dec, temp_uni, peligro and gas. busy=1 from cycle k+1.
- Start while busy=1: ignored, with no queueing. Input changes after accept have no effect.
- States: IDLE -> LOAD -> BIT_HI -> BIT_LO -> (next bit: BIT_HI | last bit: GAP) -> (more bytes: LOAD | last byte: IDLE).
- Frame: 11 bits:
  - start bit 0;
  - data bits D0..D7, LSB first;
  - odd parity bit = ~^byte;
  - stop bit 1.
- Bit timing:
  - ps2_data changes only at entry to BIT_HI.
  - BIT_HI holds ps2_clk=1 for CLK_DIV cycles, then BIT_LO holds ps2_clk=0 for CLK_DIV cycles. The receiver samples on the falling edge.
- Per-byte time is 22*CLK_DIV + GAP_CYC cycles, and the gap follows every byte including the last.
- Message timing:
  - busy stays high for exactly N*(22*CLK_DIV+GAP_CYC) cycles, where N = byte count.
  - done=1 for exactly the first cycle busy=0.
  - A start in that same cycle is accepted.
- LOAD takes 0 extra cycles: the start bit is driven in cycle k+1.
- Counters:
  - Divider counter is sized for max(CLK_DIV, GAP_CYC) and wraps to 0 on each phase change.
  - Bit index 0..10.
  - Byte index 0..3; it saturates and never wraps into a stale byte.
- RST mid-message: the next cycle gives ps2_clk=1, ps2_data=1, busy=0, done=0 and IDLE. The partial frame is abandoned and no done pulse is issued.
- RST and start in the same cycle: reset wins and start is dropped.

Optional Feature:
- Macro: PS2_BREAK_CODE_EN.
- Defined:
  - Every byte B after the leading 0x43 is followed by the break pair 0xF0, B, each as a full frame plus gap.
  - Byte counts become TEMP 10, ALARM 7, GAS 7, RESET 4; the 0x43 is sent make-only.
  - The byte index widens to 4 bits.
- Undefined: make codes only, as listed above, with zero added logic.

Test Plan:
- Reset idle: RST held 3 cycles, then released → ps2_clk=1, ps2_data=1, busy=0, done=0 for 100 cycles with start=0.
- TEMP frame (CLK_DIV=4, GAP_CYC=8, temp_dec=0x1E, temp_uni=0x2E) → falling-edge bit captures:
  - 0x43 → 0,1,1,0,0,0,0,1,0,0,1 (parity 0);
  - 0x5A → 0,0,1,0,1,1,0,1,0,1,1 (parity 1);
  - then 0x1E, 0x2E;
  - busy high for 4*(88+8)=384 cycles; done pulses once.
- ALARM/GAS variants: cmd=1, peligro=1 → bytes 43,33,4D in 288 cycles. cmd=2, gas=0 → bytes 43,34,31.
- Start while busy: a second start pulse at byte 1 of RESET (cmd=3) → only 43,2D sent; busy low after 192 cycles; inputs changed mid-message do not alter bytes.
- Mid-frame reset: RST asserted at bit 5 of byte 2 → next cycle lines high, busy=0, no done. A following cmd=3 start sends a clean 43,2D.
- PS2_BREAK_CODE_EN defined, cmd=3 → bytes 43,2D,F0,2D; busy 4*(22*CLK_DIV+GAP_CYC) cycles.
